drone_esc_pwm_gen: RTL
======================

// Module: drone_esc_pwm_gen
// PURPOSE
//  Quad ESC pulse generator; the stage directly downstream of the BLDC-motor AXI4-Lite slave register file.
//  Consumes the four per-motor throttle registers (slv_reg0..3) and the arm bit.
//  Emits four standard ESC servo-style PWM pulses, default 400 Hz frame and 1000-2000 us high time.
//  Width changes are applied only at frame boundaries, so an output pulse never glitches.
//  Arming is gated by a safety sequence.
// PARAMETERS
//  NUM_MOTORS  4     number of PWM channels
//  THR_W       16    width of each throttle input field
//  TICK_DIV    100   clocks per 1 us tick (100 MHz clock)
//  PERIOD_US   2500  frame length in ticks (400 Hz)
//  MIN_US      1000  idle/stop pulse width in ticks
//  MAX_US      2000  full-throttle pulse width in ticks; must satisfy MIN_US < MAX_US < PERIOD_US
//  ARM_FRAMES  200   frames of MIN_US pulses required before throttle is honoured (0.5 s)
// PORTS
//  s00_axi_aclk     in   1                 single clock, all logic rising edge
//  s00_axi_aresetn  in   1                 asynchronous active-low reset
//  throttle_in      in   NUM_MOTORS*THR_W  packed; motor i = [i*THR_W +: THR_W]; unsigned us above MIN_US
//  arm              in   1                 1 = request armed (register bit, same clock domain)
//  pwm_out          out  NUM_MOTORS        ESC pulse outputs, registered
//  frame_start      out  1                 1-cycle pulse at each frame boundary
//  armed            out  1                 1 while FSM is in ARMED
// BEHAVIOUR
//  Reset (async, aresetn=0):
//   - pwm_out=0, frame_start=0, armed=0
//   - FSM=DISARMED; prescaler=0, period_cnt=0, arm_cnt=0; every shadow width = MIN_US
//   - Reset asserted mid-pulse drives pwm_out low immediately.
//  Timing:
//   - Prescaler counts 0..TICK_DIV-1; us_tick=1 on the cycle it equals TICK_DIV-1, then it wraps to 0.
//   - period_cnt advances on us_tick over 0..PERIOD_US-1.
//   - When us_tick and period_cnt==PERIOD_US-1: period_cnt->0, frame_start=1 on the next cycle,
//     shadow widths load, FSM evaluates.
//   - pwm_out[i] <= (period_cnt < shadow[i]), registered, so pwm_out lags period_cnt by 1 clock.
//   - High time is exactly shadow[i]*TICK_DIV clocks; the first frame after reset starts at period_cnt=0.
//  Width computation, at frame load:
//   - t = throttle_in[i], clamped to (MAX_US-MIN_US) if larger (unsigned compare, no wrap)
//   - shadow[i] = MIN_US + t when FSM=ARMED, else MIN_US
//   - Inputs are sampled only at the frame load; mid-frame throttle changes affect the next frame only.
//  FSM (evaluated on frame load, except disarm):
//   - DISARMED: arm=1 -> ARMING, arm_cnt=0.
//   - ARMING: arm_cnt++ per frame; arm_cnt==ARM_FRAMES-1 -> ARMED; arm=0 -> DISARMED.
//   - ARMED: armed=1.
//   - Disarm: arm=0 in any state -> DISARMED on the next clock, not waiting for a frame; armed drops
//     1 clock after arm falls.
//   - An in-flight pulse finishes with its latched width; the next frame is MIN_US.
//   - arm re-asserted while ARMING/ARMED: no restart. Arm toggled 1->0->1 within one frame: arming
//     restarts from arm_cnt=0.
//  Outputs while DISARMED/ARMING: continuous MIN_US pulses, which keep the ESCs calibrated and stopped.
// STRUCTURE
//  Package drone_esc_pkg:
//   - typedef enum logic [1:0] {ESC_DISARMED, ESC_ARMING, ESC_ARMED} esc_state_t
//   - localparam defaults for TICK_DIV/PERIOD_US/MIN_US/MAX_US
//   - function clamp_width()
//  Sub-module esc_tick_gen: prescaler + period counter, producing us_tick, period_cnt and frame_load.
//  The channel compare logic and FSM live in drone_esc_pwm_gen, channels in a generate loop.
//  Counter widths are $clog2 of the respective maxima.
// TESTING  (bench params: TICK_DIV=4, PERIOD_US=50, MIN_US=10, MAX_US=20, ARM_FRAMES=2)
//  1. Reset, arm=0, throttle=5 on all channels -> every frame each pwm_out high 40 clk, low 160 clk;
//     armed=0; frame_start every 200 clk.
//  2. arm=1 at frame 0 -> two frames of 40-clk pulses, armed rises at 2nd frame load; following
//     frames 60-clk pulses.
//  3. Armed, throttle_in ch0=100, ch1=0, ch2=10, ch3=0xFFFF -> high times 80/40/80/80 clk
//     (clamp, no wrap).
//  4. Armed, change ch0 throttle 5->8 at period_cnt=3 -> current frame stays 60 clk, next frame 72 clk.
//  5. Armed, arm=0 mid-pulse -> armed=0 after 1 clk, current pulse completes at 60 clk, next frame
//     40 clk.
//  6. aresetn=0 while pwm_out high -> pwm_out=0 same cycle; after release, behaviour as test 1.

Source files
------------

// File: rtl/drone_esc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : drone_esc_pkg
// Description : Shared types, default timing constants and the throttle
//               clamp helper for the quad ESC pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package drone_esc_pkg;

    // Arming state machine encoding
    typedef enum logic [1:0] {
        ESC_DISARMED = 2'd0,
        ESC_ARMING   = 2'd1,
        ESC_ARMED    = 2'd2
    } esc_state_t;

    // Default timing for a 100 MHz clock, 400 Hz frame, 1000-2000 us pulses
    localparam int ESC_TICK_DIV  = 100;
    localparam int ESC_PERIOD_US = 2500;
    localparam int ESC_MIN_US    = 1000;
    localparam int ESC_MAX_US    = 2000;

    // Saturate a throttle value to the usable span; unsigned, so huge
    // register values pin to full throttle instead of wrapping.
    function automatic logic [31:0] clamp_width(input logic [31:0] t,
                                                input logic [31:0] span);
        return (t > span) ? span : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/esc_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : esc_tick_gen
// Description : Microsecond prescaler and frame period counter. Produces the
//               1 us tick, the position inside the frame and the frame-load
//               strobe on the last tick of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module esc_tick_gen #(
    parameter int TICK_DIV  = 100,
    parameter int PERIOD_US = 2500,
    parameter int PC_W      = $clog2(PERIOD_US)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            us_tick,
    output logic [PC_W-1:0] period_cnt,
    output logic            frame_load
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PS_W-1:0] prescaler;

    assign us_tick    = (prescaler == PS_W'(TICK_DIV - 1));
    assign frame_load = us_tick && (period_cnt == PC_W'(PERIOD_US - 1));

    // Prescaler: count 0..TICK_DIV-1, wrap on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (us_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Frame position: advance once per us, restart at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (frame_load) begin
            period_cnt <= '0;
        end else if (us_tick) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/drone_esc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : drone_esc_pwm_gen
// Description : Quad ESC servo-style pulse generator. Throttle widths are
//               latched only at frame boundaries so pulses never glitch, and
//               throttle is honoured only after an arming sequence of
//               ARM_FRAMES idle frames. Dropping arm disarms on the next clock.
// Revision    : 1.0 - initial release
// ============================================================================
module drone_esc_pwm_gen
    import drone_esc_pkg::*;
#(
    parameter int NUM_MOTORS = 4,
    parameter int THR_W      = 16,
    parameter int TICK_DIV   = ESC_TICK_DIV,
    parameter int PERIOD_US  = ESC_PERIOD_US,
    parameter int MIN_US     = ESC_MIN_US,
    parameter int MAX_US     = ESC_MAX_US,
    parameter int ARM_FRAMES = 200
) (
    input  logic                        s00_axi_aclk,
    input  logic                        s00_axi_aresetn,
    input  logic [NUM_MOTORS*THR_W-1:0] throttle_in,
    input  logic                        arm,
    output logic [NUM_MOTORS-1:0]       pwm_out,
    output logic                        frame_start,
    output logic                        armed
);

    localparam int          PC_W = $clog2(PERIOD_US);
    localparam int          AC_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
    localparam logic [31:0] SPAN = 32'(MAX_US - MIN_US);

    logic                  us_tick;
    logic                  frame_load;
    logic [PC_W-1:0]       period_cnt;
    logic [NUM_MOTORS-1:0] pwm_next;

    esc_state_t            state;
    esc_state_t            state_d;
    logic [AC_W-1:0]       arm_cnt;
    logic [AC_W-1:0]       arm_cnt_d;

    // The raw us tick is carried out of the timebase for observation only;
    // all channel and FSM timing keys off frame_load.
    logic                  tick_unused;
    assign tick_unused = us_tick;

    esc_tick_gen #(
        .TICK_DIV  (TICK_DIV),
        .PERIOD_US (PERIOD_US),
        .PC_W      (PC_W)
    ) u_tick_gen (
        .clk        (s00_axi_aclk),
        .rst_n      (s00_axi_aresetn),
        .us_tick    (us_tick),
        .period_cnt (period_cnt),
        .frame_load (frame_load)
    );

    // Arming state and frame counter register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state   <= ESC_DISARMED;
            arm_cnt <= '0;
        end else begin
            state   <= state_d;
            arm_cnt <= arm_cnt_d;
        end
    end

    // Next-state: disarm is immediate, every other transition waits for a frame load
    always_comb begin
        state_d   = state;
        arm_cnt_d = arm_cnt;
        if (!arm) begin
            state_d   = ESC_DISARMED;
            arm_cnt_d = '0;
        end else if (frame_load) begin
            case (state)
                ESC_DISARMED: begin
                    state_d   = ESC_ARMING;
                    arm_cnt_d = '0;
                end
                ESC_ARMING: begin
                    if (arm_cnt == AC_W'(ARM_FRAMES - 1)) begin
                        state_d = ESC_ARMED;
                    end else begin
                        arm_cnt_d = arm_cnt + 1'b1;
                    end
                end
                ESC_ARMED: begin
                    state_d = ESC_ARMED;
                end
                default: begin
                    state_d   = ESC_DISARMED;
                    arm_cnt_d = '0;
                end
            endcase
        end
    end

    assign armed = (state == ESC_ARMED);

    // Per-channel shadow width and compare. The width uses the state being
    // entered at this load, so the first armed frame already carries throttle.
    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
        logic [THR_W-1:0] thr;
        logic [PC_W-1:0]  width_d;
        logic [PC_W-1:0]  shadow;

        assign thr     = throttle_in[i*THR_W +: THR_W];
        assign width_d = (state_d == ESC_ARMED)
                       ? PC_W'(32'(MIN_US) + clamp_width(32'(thr), SPAN))
                       : PC_W'(MIN_US);

        // Latch the pulse width only at the frame boundary
        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                shadow <= PC_W'(MIN_US);
            end else if (frame_load) begin
                shadow <= width_d;
            end
        end

        assign pwm_next[i] = (period_cnt < shadow);
    end

    // Registered pulse outputs and frame marker
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            pwm_out     <= pwm_next;
            frame_start <= frame_load;
        end
    end

endmodule
`default_nettype wire
